// File: rtl/sine_osc_ctrl.sv
// sine_osc_ctrl: sequencer for the 48 kHz coupled-form sine oscillator.
// Owns the frequency code driven into the external freq2trig lookup and,
// on each sample tick, time-shares one WLxWL multiplier over four cycles
// to rotate the (x, y) state vector. y is emitted as the audio sample.
module sine_osc_ctrl #(
    parameter int WL  = 16,
    parameter int AMP = 32767
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           freq_in,
    input  logic                 freq_we,
    input  logic                 tick,
    input  logic signed [WL-1:0] cos_w,
    input  logic signed [WL-1:0] sin_w,
    output logic [7:0]           trig_freq,
    output logic signed [WL-1:0] sample,
    output logic                 sample_vld,
    output logic                 busy,
    output logic                 overrun
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        MUL0,
        MUL1,
        MUL2,
        MUL3,
        UPD
    } state_t;

    // Rounding bias 2^(WL-2) and symmetric saturation limits, all in acc width.
    localparam logic signed [2*WL:0] RND  = {{(WL+2){1'b0}}, 1'b1, {(WL-2){1'b0}}};
    localparam logic signed [2*WL:0] MAXV = {{(WL+2){1'b0}}, {(WL-1){1'b1}}};
    localparam logic signed [2*WL:0] MINV = -MAXV;

    state_t state, state_nxt;

    logic [7:0]           freq_buf;
    logic                 freq_pend;
    logic                 freq_pend_nxt;
    logic                 tick_pend;
    logic                 tick_pend_nxt;
    logic                 freq_req;
    logic                 tick_set;
    logic                 tick_consume;
    logic                 tick_drop;
    logic                 disabled;

    logic signed [WL-1:0]   x;
    logic signed [WL-1:0]   y;
    logic signed [WL-1:0]   xn;
    logic signed [WL-1:0]   yn;
    logic signed [WL-1:0]   op_a;
    logic signed [WL-1:0]   op_b;
    logic signed [2*WL-1:0] prod;
    logic signed [2*WL:0]   prod_ext;
    logic signed [2*WL:0]   acc;
    logic signed [2*WL:0]   acc_sum;
    logic signed [2*WL:0]   acc_rnd;
    logic signed [2*WL:0]   acc_shr;
    logic signed [WL-1:0]   res;

    // A write seen this cycle counts as pending so IDLE can go straight to LOAD.
    assign freq_req = freq_pend | freq_we;

    // Codes outside 1..240 have no valid coefficients: run the FSM but hold state.
    assign disabled = (trig_freq == 8'd0) || (trig_freq > 8'd240);

    // Pending-request bookkeeping for frequency writes and sample ticks.
    always_comb begin
        tick_consume  = 1'b0;
        tick_set      = 1'b0;
        tick_drop     = 1'b0;
        freq_pend_nxt = freq_pend;
        // Consumption: IDLE without a frequency request, or LOAD chaining into MUL0.
        if (state == IDLE) begin
            tick_consume = !freq_req && (tick || tick_pend);
        end else if (state == LOAD) begin
            tick_consume = !freq_we && tick_pend;
        end
        // A tick is queued unless IDLE can start on it immediately.
        tick_set      = tick && !((state == IDLE) && !freq_req);
        tick_drop     = tick_set && tick_pend && !tick_consume;
        tick_pend_nxt = tick_set || (tick_pend && !tick_consume);
        if (freq_we) begin
            freq_pend_nxt = 1'b1;
        end else if (state == LOAD) begin
            freq_pend_nxt = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. LOAD chains directly into MUL0 when a tick is waiting so
    // a tick coincident with a frequency write costs only one extra cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (freq_req) begin
                    state_nxt = LOAD;
                end else if (tick || tick_pend) begin
                    state_nxt = MUL0;
                end
            end
            LOAD: begin
                if (!freq_we && tick_pend) begin
                    state_nxt = MUL0;
                end else begin
                    state_nxt = IDLE;
                end
            end
            MUL0:    state_nxt = MUL1;
            MUL1:    state_nxt = MUL2;
            MUL2:    state_nxt = MUL3;
            MUL3:    state_nxt = UPD;
            UPD:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM-derived outputs.
    always_comb begin
        busy = (state != IDLE);
    end

    // Shared multiplier operand selection: c*x, s*y, s*x, c*y.
    always_comb begin
        op_a = cos_w;
        op_b = x;
        case (state)
            MUL0: begin
                op_a = cos_w;
                op_b = x;
            end
            MUL1: begin
                op_a = sin_w;
                op_b = y;
            end
            MUL2: begin
                op_a = sin_w;
                op_b = x;
            end
            MUL3: begin
                op_a = cos_w;
                op_b = y;
            end
            default: begin
                op_a = cos_w;
                op_b = x;
            end
        endcase
    end

    // Product, accumulate, round-half-up and symmetric saturation.
    always_comb begin
        prod     = (2*WL)'(op_a) * (2*WL)'(op_b);
        prod_ext = {prod[2*WL-1], prod};
        case (state)
            MUL1:    acc_sum = acc - prod_ext;
            MUL3:    acc_sum = acc + prod_ext;
            default: acc_sum = prod_ext;
        endcase
        acc_rnd = acc_sum + RND;
        acc_shr = acc_rnd >>> (WL-1);
        if (acc_shr > MAXV) begin
            res = MAXV[WL-1:0];
        end else if (acc_shr < MINV) begin
            res = MINV[WL-1:0];
        end else begin
            res = acc_shr[WL-1:0];
        end
    end

    // Datapath and control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            trig_freq  <= '0;
            sample     <= '0;
            sample_vld <= 1'b0;
            overrun    <= 1'b0;
            freq_buf   <= '0;
            freq_pend  <= 1'b0;
            tick_pend  <= 1'b0;
            x          <= WL'(AMP);
            y          <= '0;
            xn         <= '0;
            yn         <= '0;
            acc        <= '0;
        end else begin
            sample_vld <= 1'b0;
            freq_pend  <= freq_pend_nxt;
            tick_pend  <= tick_pend_nxt;
            if (freq_we) begin
                freq_buf <= freq_in;
                overrun  <= 1'b0;
            end else if (tick_drop) begin
                overrun  <= 1'b1;
            end
            case (state)
                LOAD: begin
                    trig_freq <= freq_buf;
                    x         <= WL'(AMP);
                    y         <= '0;
                end
                MUL0, MUL2: acc <= acc_sum;
                MUL1:       xn  <= res;
                MUL3:       yn  <= res;
                UPD: begin
                    sample_vld <= 1'b1;
                    if (disabled) begin
                        sample <= '0;
                    end else begin
                        x      <= xn;
                        y      <= yn;
                        sample <= yn;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
